// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver slice.
//   rx_state_e  : receiver FSM state encoding (IDLE, START, DATA, STOP)
//   OVERSAMPLE  : ticks per serial bit period (16x oversampling)
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Read side of the UART receive buffer.
//   rd_en_i  : pop request (driven by the consumer)
//   dout_o   : popped word, valid the cycle after an accepted pop
//   empty_o  : buffer empty
//   full_o   : buffer full
// Modports:
//   master : consumer of received bytes
//   slave  : the uart_rx block
// ---------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] dout_o;
  logic                  empty_o;
  logic                  full_o;

  modport master (
    output rd_en_i,
    input  dout_o,
    input  empty_o,
    input  full_o
  );

  modport slave (
    input  rd_en_i,
    output dout_o,
    output empty_o,
    output full_o
  );

endinterface

// File: rtl/wrap_around_fifo.sv
// ---------------------------------------------------------------------------
// wrap_around_fifo
// Synchronous FIFO using pointers with one extra wrap bit, so full and empty
// are told apart without an occupancy counter. DEPTH must be a power of 2.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   wr_en_i, wr_data_i : push request and data (ignored while full)
//   rd_en_i            : pop request (ignored while empty)
//   rd_data_o          : popped word, registered, valid the cycle after pop
//   empty_o, full_o    : status flags
// ---------------------------------------------------------------------------
module wrap_around_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_empty;
  logic             w_full;
  logic             w_do_wr;
  logic             w_do_rd;

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_wr = wr_en_i & ~w_full;
  assign w_do_rd = rd_en_i & ~w_empty;

  // Storage carries no reset; only pointers define valid contents.
  always_ff @(posedge clk_i) begin
    if (w_do_wr) begin
      r_mem[r_wptr[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_do_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rptr    <= r_rptr + 1'b1;
        r_rd_data <= r_mem[r_rptr[AW-1:0]];
      end
    end
  end

  assign rd_data_o = r_rd_data;
  assign empty_o   = w_empty;
  assign full_o    = w_full;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 16x oversampling UART receiver (8N1-style framing, DATA_WIDTH data bits,
// LSB first) feeding a receive FIFO.
// Ports:
//   clk_i       : clock, all logic on rising edge
//   rst_ni      : asynchronous active-low reset
//   rx_en_i     : enables start-bit detection; a frame in flight completes
//   rx_bit_i    : asynchronous serial line, idle high
//   rx_if       : buffer read side (rd_en_i, dout_o, empty_o, full_o)
//   frame_err_o : one-cycle pulse when the stop bit is sampled low
//   overrun_o   : one-cycle pulse when a good frame is dropped (buffer full)
// Configuration:
//   UART_RX_FRAME_ERR_EN defined   : low stop bit -> frame_err_o, no push
//   UART_RX_FRAME_ERR_EN undefined : frame_err_o tied 0, frame pushed anyway
// DATA_WIDTH must be a power of 2 and at least 2.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_en_i,
  input  logic       rx_bit_i,
  uart_rx_if.slave   rx_if,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int OS_DIV = CLK_FREQ / (OVERSAMPLE * BAUD_RATE);
  localparam int TCW    = $clog2(OS_DIV) + 1;
  localparam int SCW    = $clog2(OVERSAMPLE);
  localparam int BCW    = $clog2(DATA_WIDTH) + 1;

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  w_line;
  logic [TCW-1:0]        r_tick_cnt;
  logic                  w_tick;

  rx_state_e             r_state;
  rx_state_e             w_state_nxt;
  logic [SCW-1:0]        r_samp_cnt;
  logic [SCW-1:0]        w_samp_nxt;
  logic [BCW-1:0]        r_bit_cnt;
  logic [BCW-1:0]        w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_done;

  logic                  w_push_req;
  logic                  w_wr_en;
  logic                  r_overrun;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_bit_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;

  // Free-running oversample tick; the FSM never re-phases it, which bounds
  // the sample-point jitter to one tick period.
  assign w_tick = (r_tick_cnt == TCW'(OS_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_samp_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_samp_cnt <= w_samp_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_samp_nxt  = r_samp_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (rx_en_i && !w_line) begin
          w_state_nxt = ST_START;
          w_samp_nxt  = '0;
        end
      end

      // Re-check the line half a bit in; a high line here was a glitch.
      ST_START: begin
        if (w_tick) begin
          if (w_samp_nxt == SCW'(OVERSAMPLE / 2 - 1) && r_samp_cnt == SCW'(OVERSAMPLE / 2 - 1)) begin
            if (!w_line) begin
              w_state_nxt = ST_DATA;
              w_samp_nxt  = '0;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = ST_IDLE;
              w_samp_nxt  = '0;
            end
          end else begin
            w_samp_nxt = r_samp_cnt + 1'b1;
          end
        end
      end

      // Sample points sit one full bit apart, i.e. mid-bit after START.
      ST_DATA: begin
        if (w_tick) begin
          if (r_samp_cnt == SCW'(OVERSAMPLE - 1)) begin
            w_samp_nxt  = '0;
            w_shift_nxt = {w_line, r_shift[DATA_WIDTH-1:1]};
            if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              w_state_nxt = ST_STOP;
              w_bit_nxt   = '0;
            end else begin
              w_bit_nxt = r_bit_cnt + 1'b1;
            end
          end else begin
            w_samp_nxt = r_samp_cnt + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          if (r_samp_cnt == SCW'(OVERSAMPLE - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
            w_samp_nxt  = '0;
          end else begin
            w_samp_nxt = r_samp_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef UART_RX_FRAME_ERR_EN
  logic r_frame_err;

  assign w_push_req = w_done & w_line;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_done & ~w_line;
    end
  end

  assign frame_err_o = r_frame_err;
`else
  assign w_push_req  = w_done;
  assign frame_err_o = 1'b0;
`endif

  // A frame arriving while full is dropped; the FIFO contents stay intact.
  assign w_wr_en = w_push_req & ~rx_if.full_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push_req & rx_if.full_o;
    end
  end

  assign overrun_o = r_overrun;

  wrap_around_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (w_wr_en),
    .wr_data_i (r_shift),
    .rd_en_i   (rx_if.rd_en_i),
    .rd_data_o (rx_if.dout_o),
    .empty_o   (rx_if.empty_o),
    .full_o    (rx_if.full_o)
  );

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, line bit rate.
REQ-003 Parameter DATA_WIDTH, default 8, data bits per frame, power of 2.
REQ-004 Parameter FIFO_DEPTH, default 16, receive buffer entries.
REQ-005 clk_i  input  1  single clock; all logic rising-edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 rx_en_i  input  1  receive enable; low = line ignored in IDLE.
REQ-008 rx_bit_i  input  1  asynchronous serial line, idle high.
REQ-009 rd_en_i  input  1  pop request from buffer.
REQ-010 dout_o  output  DATA_WIDTH  popped byte.
REQ-011 empty_o  output  1  buffer empty.
REQ-012 full_o  output  1  buffer full.
REQ-013 frame_err_o  output  1  one-cycle pulse, stop bit sampled low.
REQ-014 overrun_o  output  1  one-cycle pulse, good frame dropped because buffer full.

Function
REQ-015 rx_bit_i SHALL pass a 2-flop synchronizer, both flops resetting to 1; all decisions use the second flop.
REQ-016 A tick SHALL pulse every OS_DIV = CLK_FREQ/(16*BAUD_RATE) clocks (integer divide); the tick counter is free-running.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-018 IDLE->START when rx_en_i=1 and the synchronized line is 0; sample counter cleared.
REQ-019 In START, at the 8th tick: line 0 -> DATA with counters cleared; line 1 -> IDLE (glitch rejected, no output).
REQ-020 In DATA, every 16th tick SHALL sample one bit into the shift register, LSB first; after DATA_WIDTH bits -> STOP.
REQ-021 In STOP, at the 16th tick: line 1 -> push the byte if not full; line 0 -> frame_err_o pulse, no push; both cases -> IDLE.
REQ-022 Push with full_o=1 SHALL drop the byte, pulse overrun_o, and leave buffer contents unchanged.
REQ-023 empty_o SHALL deassert the cycle after the push cycle.
REQ-024 dout_o SHALL be valid the cycle after rd_en_i; rd_en_i while empty_o=1 is ignored.
REQ-025 A push and a pop in the same cycle SHALL both complete; occupancy is unchanged.
REQ-026 Deasserting rx_en_i mid-frame SHALL NOT abort the frame; it only blocks new start detection.

Reset
REQ-027 On rst_ni low: FSM=IDLE; all counters and the shift register 0; buffer empty; empty_o=1, full_o=0, frame_err_o=0, overrun_o=0, dout_o=0.
REQ-028 Reset mid-frame SHALL discard the partial byte; the first frame after release is received normally.

Configuration
REQ-029 Macro UART_RX_FRAME_ERR_EN defined: REQ-021 behaviour applies.
REQ-030 Macro UART_RX_FRAME_ERR_EN undefined: frame_err_o is tied 0 and a low stop bit is pushed as a good frame.

Structure
REQ-031 Package uart_pkg SHALL hold the rx state enum typedef and the oversample constant 16.
REQ-032 The buffer SHALL be the existing wrap_around_fifo sub-module, instantiated with FIFO_DEPTH and DATA_WIDTH.

Verification
REQ-033 The bench SHALL use CLK_FREQ=1_600_000 and BAUD_RATE=10_000 (OS_DIV=10, 160 clocks per bit).
REQ-034 Frame 0xA5, stop=1 -> empty_o falls; rd_en_i pulse -> dout_o=0xA5 the next cycle; no error pulses.
REQ-035 Line low for 40 clocks, then high -> FSM returns to IDLE; empty_o stays 1.
REQ-036 Frame 0x3C with stop=0 -> frame_err_o pulses exactly once; no push; with the macro undefined, 0x3C is pushed.
REQ-037 17 frames 0x00..0x10 with no reads -> full_o=1 after 16 frames; 17th frame pulses overrun_o; reads return 0x00..0x0F.
REQ-038 rst_ni low during bit 4 of 0xFF, then frame 0x5A -> only 0x5A is buffered.
REQ-039 rx_en_i=0 with frame 0x11 sent -> nothing buffered; rx_en_i=1 and 0x22 sent -> 0x22 buffered.
